icache_responder: RTL and testbench

// - Responder end of the instruction-fetch memory interface; serves the fetch stage's mem_en/mem_addr requests.
// - Direct-mapped, read-only instruction cache.
// - Hit: mem_data_o/mem_valid_o in the same cycle, combinational from the flop arrays.
// - Miss: a refill FSM fetches the whole line from the backing bus, then the request hits.
// - Sits between the IF stage and the instruction bus/arbiter.

---
 rtl/icache_responder_pkg.sv | 32 +++
 rtl/icache_responder_if.sv | 27 ++
 rtl/icache_responder_refill_ctrl.sv | 99 +++++++++
 rtl/icache_responder.sv | 107 ++++++++++
 tb/tb_icache_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_responder_pkg.sv
// Shared types, widths and helpers for the instruction cache responder.
package icache_responder_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEF_NUM_LINES  = 16;
  localparam int unsigned DEF_LINE_WORDS = 4;

  // Address field widths for a given geometry; [1:0] is the byte offset.
  function automatic int unsigned woff_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned num_lines,
                                            input int unsigned line_words);
    return ADDR_W - 2 - $clog2(line_words) - $clog2(num_lines);
  endfunction

  localparam int unsigned WOFF_W = woff_width(DEF_LINE_WORDS);
  localparam int unsigned IDX_W  = idx_width(DEF_NUM_LINES);
  localparam int unsigned TAG_W  = tag_width(DEF_NUM_LINES, DEF_LINE_WORDS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and refill-bus signals of the instruction cache, named from the cache's view.
interface icache_responder_if;
  import icache_responder_pkg::*;

  logic              mem_en_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_valid_o;
  logic              invalidate_i;
  logic              bus_req_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_i;
  logic              bus_valid_i;

  // The cache itself.
  modport slave (
    input  mem_en_i, mem_addr_i, invalidate_i, bus_data_i, bus_valid_i,
    output mem_data_o, mem_valid_o, bus_req_o, bus_addr_o
  );

  // The environment: fetch stage plus backing bus.
  modport master (
    output mem_en_i, mem_addr_i, invalidate_i, bus_data_i, bus_valid_i,
    input  mem_data_o, mem_valid_o, bus_req_o, bus_addr_o
  );

endinterface

// File: rtl/icache_responder_refill_ctrl.sv
// Line refill sequencer: latches the missing line, issues in-order beats, tracks discard.
module icache_refill_ctrl
  import icache_responder_pkg::*;
#(
  parameter int unsigned WOFF_BITS = WOFF_W,
  parameter int unsigned IDX_BITS  = IDX_W,
  parameter int unsigned TAG_BITS  = TAG_W
) (
  input  logic                          clk,
  input  logic                          rstn_i,
  input  logic                          miss_i,
  input  logic [TAG_BITS+IDX_BITS-1:0]  line_addr_i,
  input  logic                          invalidate_i,
  input  logic                          bus_valid_i,
  output logic                          refilling_o,
  output logic                          bus_req_o,
  output logic [ADDR_W-1:0]             bus_addr_o,
  output logic                          wr_en_c_o,
  output logic [IDX_BITS-1:0]           wr_idx_o,
  output logic [WOFF_BITS-1:0]          wr_woff_o,
  output logic [TAG_BITS-1:0]           wr_tag_o,
  output logic                          validate_c_o
);

  localparam int unsigned LINE_W = TAG_BITS + IDX_BITS;

  localparam logic [0:0] ST_IDLE   = 1'(IDLE);
  localparam logic [0:0] ST_REFILL = 1'(REFILL);

  localparam logic [WOFF_BITS-1:0] CNT_LAST = '1;

  logic [0:0]           state_q, state_d;
  logic [WOFF_BITS-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic                 discard_q, discard_d;

  // State, beat counter, latched line address and discard flag.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      line_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      line_q    <= line_d;
      discard_q <= discard_d;
    end
  end

  // Next-state logic and per-beat write strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    discard_d    = discard_q;
    wr_en_c_o    = 1'b0;
    validate_c_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_i) begin
          line_d    = line_addr_i;
          cnt_d     = '0;
          discard_d = 1'b0;
          state_d   = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (invalidate_i) begin
          discard_d = 1'b1;
        end
        if (bus_valid_i) begin
          wr_en_c_o = 1'b1;
          cnt_d     = WOFF_BITS'(cnt_q + WOFF_BITS'(1));
          if (cnt_q == CNT_LAST) begin
            // A fence.i seen at any point of the refill keeps the line invalid.
            validate_c_o = !discard_q && !invalidate_i;
            discard_d    = 1'b0;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus request is a pure decode of the registered state, so it holds across wait states.
  assign refilling_o = (state_q == ST_REFILL);
  assign bus_req_o   = refilling_o;
  assign bus_addr_o  = refilling_o ? ADDR_W'({line_q, cnt_q, 2'b00}) : '0;

  assign wr_idx_o  = line_q[IDX_BITS-1:0];
  assign wr_tag_o  = line_q[LINE_W-1 -: TAG_BITS];
  assign wr_woff_o = cnt_q;

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache answering fetch requests with same-cycle hits.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input logic               clk,
  input logic               rstn_i,
  icache_responder_if.slave bus_if
);

  localparam int unsigned WOFF_BITS = woff_width(LINE_WORDS);
  localparam int unsigned IDX_BITS  = idx_width(NUM_LINES);
  localparam int unsigned TAG_BITS  = tag_width(NUM_LINES, LINE_WORDS);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES][LINE_WORDS];

  logic [WOFF_BITS-1:0] req_woff;
  logic [IDX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]  req_tag;
  logic                 hit;
  logic                 miss;
  logic                 refilling;
  logic                 wr_en;
  logic                 validate;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [WOFF_BITS-1:0] wr_woff;
  logic [TAG_BITS-1:0]  wr_tag;
  logic                 unused_byte_off;

  assign req_woff = bus_if.mem_addr_i[2 +: WOFF_BITS];
  assign req_idx  = bus_if.mem_addr_i[2 + WOFF_BITS +: IDX_BITS];
  assign req_tag  = bus_if.mem_addr_i[2 + WOFF_BITS + IDX_BITS +: TAG_BITS];

  // Instruction fetches are word aligned; the byte offset carries no information.
  assign unused_byte_off = ^bus_if.mem_addr_i[1:0];

  // Lookup is suppressed while refilling so a half-written line can never hit.
  assign hit  = bus_if.mem_en_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !refilling;
  assign miss = bus_if.mem_en_i && !hit && !bus_if.invalidate_i && !refilling;

  assign bus_if.mem_valid_o = hit;
  assign bus_if.mem_data_o  = hit ? data_q[req_idx][req_woff] : '0;

  icache_refill_ctrl #(
    .WOFF_BITS (WOFF_BITS),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_refill_ctrl (
    .clk          (clk),
    .rstn_i       (rstn_i),
    .miss_i       (miss),
    .line_addr_i  ({req_tag, req_idx}),
    .invalidate_i (bus_if.invalidate_i),
    .bus_valid_i  (bus_if.bus_valid_i),
    .refilling_o  (refilling),
    .bus_req_o    (bus_if.bus_req_o),
    .bus_addr_o   (bus_if.bus_addr_o),
    .wr_en_c_o    (wr_en),
    .wr_idx_o     (wr_idx),
    .wr_woff_o    (wr_woff),
    .wr_tag_o     (wr_tag),
    .validate_c_o (validate)
  );

  // Valid bits: fence.i dominates; a new refill drops the victim line before overwriting it.
  always_comb begin
    valid_d = valid_q;
    if (bus_if.invalidate_i) begin
      valid_d = '0;
    end else begin
      if (miss) begin
        valid_d[req_idx] = 1'b0;
      end
      if (validate) begin
        valid_d[wr_idx] = 1'b1;
      end
    end
  end

  // Valid array is the only storage that needs a reset value.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag written with the final beat of a refill.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_woff == WOFF_BITS'(LINE_WORDS - 1))) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  // Refill data, one word per accepted bus beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx][wr_woff] <= bus_if.bus_data_i;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Scenario bench for icache_responder with a backing-bus model and beat-address scoreboard.
module tb_icache_responder;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   wait_states;
  logic [31:0] exp_q[$];

  icache_responder_if bif();

  icache_responder dut (
    .clk    (clk),
    .rstn_i (rstn),
    .bus_if (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory contents: the 0x100 line holds 0xA0..0xA3, everything else is address-derived.
  function automatic logic [31:0] model(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + 32'(a[3:2]);
    return 32'hD000_0000 ^ a;
  endfunction

  task automatic push_line(input logic [31:0] a);
    for (int w = 0; w < 4; w++) exp_q.push_back({a[31:4], 4'b0000} + 32'(w * 4));
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (bif.mem_valid_o !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  // Bus model: accepts a beat after wait_states idle cycles, data from the memory model.
  initial begin
    int wcnt;
    wcnt = 0;
    bif.bus_valid_i = 1'b0;
    bif.bus_data_i  = '0;
    forever begin
      @(negedge clk);
      if (rstn && bif.bus_req_o) begin
        if (wcnt < wait_states) begin
          bif.bus_valid_i = 1'b0;
          wcnt++;
        end else begin
          bif.bus_valid_i = 1'b1;
          bif.bus_data_i  = model(bif.bus_addr_o);
          wcnt = 0;
        end
      end else begin
        bif.bus_valid_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Scoreboard: every accepted beat must carry the next expected address; address holds while waiting.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rstn && bif.bus_req_o) begin
        checks++;
        if (bif.mem_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL refill_mem_valid: got %b expected 0", bif.mem_valid_o);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got addr %h expected no request", bif.bus_addr_o);
        end else if (bif.bus_valid_i) begin
          e = exp_q.pop_front();
          if (bif.bus_addr_o !== e) begin
            errors++;
            $display("FAIL beat_addr: got %h expected %h", bif.bus_addr_o, e);
          end
        end else if (bif.bus_addr_o !== exp_q[0]) begin
          errors++;
          $display("FAIL wait_addr_stable: got %h expected %h", bif.bus_addr_o, exp_q[0]);
        end
      end
    end
  end

  task automatic test_reset();
    rstn = 1'b0;
    bif.mem_en_i = 1'b0;
    bif.mem_addr_i = '0;
    bif.invalidate_i = 1'b0;
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bif.mem_valid_o); end
    checks++; if (bif.mem_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", bif.mem_data_o); end
    checks++; if (bif.bus_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bif.bus_req_o); end
    checks++; if (bif.bus_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", bif.bus_addr_o); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_cold_miss();
    int cyc;
    @(negedge clk);
    push_line(32'h100);
    bif.mem_en_i = 1'b1;
    bif.mem_addr_i = 32'h100;
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0 || bif.mem_data_o !== 32'h0) begin errors++; $display("FAIL cold_first: got %b/%h expected 0/0", bif.mem_valid_o, bif.mem_data_o); end
    wait_valid(20, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL cold_latency: got %0d expected 5", cyc); end
    checks++; if (bif.mem_data_o !== 32'hA0) begin errors++; $display("FAIL cold_data: got %h expected a0", bif.mem_data_o); end
    @(negedge clk);
    bif.mem_addr_i = 32'h10C;
    #1;
    checks++; if (bif.mem_valid_o !== 1'b1 || bif.mem_data_o !== 32'hA3) begin errors++; $display("FAIL cold_hit_w3: got %b/%h expected 1/a3", bif.mem_valid_o, bif.mem_data_o); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL cold_beats: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_conflict();
    int cyc;
    @(negedge clk);
    push_line(32'h200);
    bif.mem_addr_i = 32'h200;
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0) begin errors++; $display("FAIL conflict_miss: got %b expected 0", bif.mem_valid_o); end
    wait_valid(20, cyc);
    checks++; if (cyc !== 5 || bif.mem_data_o !== model(32'h200)) begin errors++; $display("FAIL conflict_fill: got %0d/%h expected 5/%h", cyc, bif.mem_data_o, model(32'h200)); end
    @(negedge clk);
    push_line(32'h100);
    bif.mem_addr_i = 32'h100;
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0) begin errors++; $display("FAIL conflict_evict: got %b expected 0", bif.mem_valid_o); end
    wait_valid(20, cyc);
    checks++; if (cyc !== 5 || bif.mem_data_o !== 32'hA0) begin errors++; $display("FAIL conflict_back: got %0d/%h expected 5/a0", cyc, bif.mem_data_o); end
  endtask

  task automatic test_wait_states();
    int cyc;
    wait_states = 3;
    @(negedge clk);
    push_line(32'h440);
    bif.mem_addr_i = 32'h448;
    #1;
    wait_valid(60, cyc);
    checks++; if (cyc !== 17) begin errors++; $display("FAIL wait_latency: got %0d expected 17", cyc); end
    checks++; if (bif.mem_data_o !== model(32'h448)) begin errors++; $display("FAIL wait_data: got %h expected %h", bif.mem_data_o, model(32'h448)); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wait_beats: got %0d left expected 0", exp_q.size()); end
    wait_states = 0;
  endtask

  task automatic test_branch();
    int  cyc;
    bit  got;
    @(negedge clk);
    bif.mem_en_i = 1'b0;
    bif.invalidate_i = 1'b1;
    @(negedge clk);
    bif.invalidate_i = 1'b0;
    push_line(32'h100);
    push_line(32'h300);
    bif.mem_en_i = 1'b1;
    bif.mem_addr_i = 32'h100;
    cyc = 0;
    got = 1'b0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      if (c == 2) bif.mem_addr_i = 32'h300;
      #1;
      if (bif.mem_valid_o === 1'b1) begin got = 1'b1; cyc = c; end
    end
    checks++; if (cyc !== 10) begin errors++; $display("FAIL branch_latency: got %0d expected 10", cyc); end
    checks++; if (bif.mem_data_o !== model(32'h300)) begin errors++; $display("FAIL branch_data: got %h expected %h", bif.mem_data_o, model(32'h300)); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL branch_beats: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_invalidate();
    int cyc;
    // fence.i on the last beat
    @(negedge clk);
    push_line(32'h100);
    bif.mem_addr_i = 32'h100;
    repeat (4) @(negedge clk);
    bif.invalidate_i = 1'b1;
    @(negedge clk);
    bif.invalidate_i = 1'b0;
    push_line(32'h100);
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0) begin errors++; $display("FAIL inv_last_beat: got %b expected 0", bif.mem_valid_o); end
    wait_valid(20, cyc);
    checks++; if (cyc !== 5 || bif.mem_data_o !== 32'hA0) begin errors++; $display("FAIL inv_refetch: got %0d/%h expected 5/a0", cyc, bif.mem_data_o); end
    // fence.i in the middle of a refill
    @(negedge clk);
    push_line(32'h500);
    bif.mem_addr_i = 32'h500;
    repeat (2) @(negedge clk);
    bif.invalidate_i = 1'b1;
    @(negedge clk);
    bif.invalidate_i = 1'b0;
    repeat (2) @(negedge clk);
    push_line(32'h500);
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0) begin errors++; $display("FAIL inv_discard: got %b expected 0", bif.mem_valid_o); end
    wait_valid(20, cyc);
    checks++; if (cyc !== 5 || bif.mem_data_o !== model(32'h500)) begin errors++; $display("FAIL inv_discard_refetch: got %0d/%h expected 5/%h", cyc, bif.mem_data_o, model(32'h500)); end
    // fence.i while idle and hitting
    @(negedge clk);
    bif.invalidate_i = 1'b1;
    #1;
    checks++; if (bif.mem_valid_o !== 1'b1) begin errors++; $display("FAIL inv_idle_same_cycle: got %b expected 1", bif.mem_valid_o); end
    @(negedge clk);
    bif.invalidate_i = 1'b0;
    push_line(32'h500);
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0 || bif.bus_req_o !== 1'b0) begin errors++; $display("FAIL inv_idle_next: got valid %b req %b expected 0/0", bif.mem_valid_o, bif.bus_req_o); end
    wait_valid(20, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL inv_idle_refill: got %0d expected 5", cyc); end
  endtask

  task automatic test_reset_mid_refill();
    int cyc;
    @(negedge clk);
    push_line(32'h100);
    bif.mem_addr_i = 32'h100;
    #1;
    wait_valid(20, cyc);
    @(negedge clk);
    push_line(32'h640);
    bif.mem_addr_i = 32'h640;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (bif.bus_req_o !== 1'b0 || bif.mem_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid: got req %b valid %b expected 0/0", bif.bus_req_o, bif.mem_valid_o); end
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    push_line(32'h100);
    bif.mem_addr_i = 32'h100;
    #1;
    checks++; if (bif.mem_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_miss: got %b expected 0", bif.mem_valid_o); end
    wait_valid(20, cyc);
    checks++; if (cyc !== 5 || bif.mem_data_o !== 32'hA0) begin errors++; $display("FAIL rst_mid_refill: got %0d/%h expected 5/a0", cyc, bif.mem_data_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wait_states = 0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_wait_states();
    test_branch();
    test_invalidate();
    test_reset_mid_refill();
    @(negedge clk);
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL final_scoreboard: got %0d left expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
